// File: rtl/fpmul_arbiter.sv
// -----------------------------------------------------------------------------
// fpmul_arbiter
//   Two requesters share one single-precision floating-point multiplier.
//   An IDLE/CALC/RESP controller accepts one operand pair at a time, computes
//   the product and holds the result until the consumer takes it. Results
//   carrying an underflow or overflow flag are counted in a saturating counter.
//
//   Ports
//     clk                  : single clock, rising edge
//     rst                  : synchronous active-high reset
//     in0_valid/in1_valid  : operand request from requester 0/1
//     in0_ready/in1_ready  : accept strobe to requester 0/1
//     in0_a/in0_b          : requester 0 operands (IEEE 754 single)
//     in1_a/in1_b          : requester 1 operands (IEEE 754 single)
//     res_valid            : result presented
//     res_ready            : consumer accepts result
//     res_id               : requester that owns the result
//     res_prod             : product
//     res_uflow/res_oflow  : underflow / overflow flags of the product
//     exc_cnt              : saturating count of flagged results
//
//   Also contains floating_point_spmul, the combinational multiplier core.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// floating_point_spmul
//   Combinational single-precision multiplier. The hidden bit is always
//   assumed, the mantissa is truncated, and out-of-range exponents clamp to
//   a signed infinity (o_flow) or a signed zero (u_flow). Zero, infinity and
//   NaN operands receive no special treatment.
//
//   Ports
//     a, b    : operands
//     f_prod  : product
//     u_flow  : exponent fell to 0 or below
//     o_flow  : exponent reached 255 or above
// -----------------------------------------------------------------------------
module floating_point_spmul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] f_prod,
    output logic        u_flow,
    output logic        o_flow
);

    logic               sign;
    logic [23:0]        man_a;
    logic [23:0]        man_b;
    logic [24:0]        prod_hi;    // product bits [47:23]
    logic signed [9:0]  exp_sum;
    logic [22:0]        man_out;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        sign    = a[31] ^ b[31];
        man_a   = {1'b1, a[22:0]};
        man_b   = {1'b1, b[22:0]};
        // Widen before multiplying so the full 48-bit product is kept, then
        // keep only the bits that can reach the truncated mantissa.
        prod_hi = 25'(({24'd0, man_a} * {24'd0, man_b}) >> 23);
        // A product of two [1,2) mantissas lands in [1,4); bit 47 set means
        // one extra normalisation shift and one more in the exponent.
        exp_sum = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
                + $signed({9'd0, prod_hi[24]}) - 10'sd127;
        man_out = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];

        f_prod  = {sign, exp_sum[7:0], man_out};
        u_flow  = 1'b0;
        o_flow  = 1'b0;
        if (exp_sum >= 10'sd255) begin
            f_prod = {sign, 8'hFF, 23'd0};
            o_flow = 1'b1;
        end else if (exp_sum <= 10'sd0) begin
            f_prod = {sign, 31'd0};
            u_flow = 1'b1;
        end
    end

endmodule

module fpmul_arbiter #(
    parameter bit RR_EN = 1'b1   // 1: round-robin, 0: requester 0 always wins
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in0_valid,
    input  logic        in1_valid,
    output logic        in0_ready,
    output logic        in1_ready,
    input  logic [31:0] in0_a,
    input  logic [31:0] in0_b,
    input  logic [31:0] in1_a,
    input  logic [31:0] in1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic [31:0] res_prod,
    output logic        res_uflow,
    output logic        res_oflow,
    output logic [7:0]  exc_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t      state;
    logic        last_gnt;
    logic        grant;
    logic        id_q;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] f_prod;
    logic        u_flow;
    logic        o_flow;

    floating_point_spmul u_mul (
        .a      (op_a),
        .b      (op_b),
        .f_prod (f_prod),
        .u_flow (u_flow),
        .o_flow (o_flow)
    );

    // Under contention round-robin favours whoever did not win last time.
    always_comb begin
        grant = 1'b0;
        if (in0_valid && in1_valid)
            grant = RR_EN ? ~last_gnt : 1'b0;
        else if (in1_valid)
            grant = 1'b1;
    end

    // Ready must follow valid within the same cycle, so it is decoded from the
    // registered state rather than registered itself. Gating with rst keeps
    // both strobes low during reset regardless of the state register.
    assign in0_ready = (state == IDLE) && !rst && in0_valid && !grant;
    assign in1_ready = (state == IDLE) && !rst && in1_valid &&  grant;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            id_q      <= 1'b0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_prod  <= 32'd0;
            res_uflow <= 1'b0;
            res_oflow <= 1'b0;
            exc_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in0_valid && in0_ready) begin
                        op_a     <= in0_a;
                        op_b     <= in0_b;
                        id_q     <= 1'b0;
                        last_gnt <= 1'b0;
                        state    <= CALC;
                    end else if (in1_valid && in1_ready) begin
                        op_a     <= in1_a;
                        op_b     <= in1_b;
                        id_q     <= 1'b1;
                        last_gnt <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // The owner id is copied here so the result registers only
                    // change when a new result is presented.
                    res_prod  <= f_prod;
                    res_uflow <= u_flow;
                    res_oflow <= o_flow;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                        if ((res_uflow || res_oflow) && (exc_cnt != 8'hFF))
                            exc_cnt <= exc_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpmul_arbiter
//   Directed bench for fpmul_arbiter. Two instances share all inputs: one
//   round-robin (r_*), one fixed priority (f_*). Inputs change just after the
//   falling edge and outputs are sampled there, half a cycle from the active
//   edge. Expected products are hand-computed IEEE 754 constants.
// -----------------------------------------------------------------------------
module tb_fpmul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid, res_ready;
    logic [31:0] in0_a, in0_b, in1_a, in1_b;

    logic        r_in0_ready, r_in1_ready, r_res_valid, r_res_id, r_res_uflow, r_res_oflow;
    logic [31:0] r_res_prod;
    logic [7:0]  r_exc_cnt;
    logic        f_in0_ready, f_in1_ready, f_res_valid, f_res_id, f_res_uflow, f_res_oflow;
    logic [31:0] f_res_prod;
    logic [7:0]  f_exc_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpmul_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in1_valid(in1_valid),
        .in0_ready(r_in0_ready), .in1_ready(r_in1_ready),
        .in0_a(in0_a), .in0_b(in0_b), .in1_a(in1_a), .in1_b(in1_b),
        .res_valid(r_res_valid), .res_ready(res_ready), .res_id(r_res_id),
        .res_prod(r_res_prod), .res_uflow(r_res_uflow), .res_oflow(r_res_oflow),
        .exc_cnt(r_exc_cnt)
    );

    fpmul_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in1_valid(in1_valid),
        .in0_ready(f_in0_ready), .in1_ready(f_in1_ready),
        .in0_a(in0_a), .in0_b(in0_b), .in1_a(in1_a), .in1_b(in1_b),
        .res_valid(f_res_valid), .res_ready(res_ready), .res_id(f_res_id),
        .res_prod(f_res_prod), .res_uflow(f_res_uflow), .res_oflow(f_res_oflow),
        .exc_cnt(f_exc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic chkw2(input string tag, input logic [31:0] obs_r, input logic [31:0] obs_f,
                         input logic [31:0] exp);
        chk({"rr ", tag}, obs_r, exp);
        chk({"fp ", tag}, obs_f, exp);
    endtask

    task automatic chkb2(input string tag, input logic obs_r, input logic obs_f, input logic exp);
        chkb({"rr ", tag}, obs_r, exp);
        chkb({"fp ", tag}, obs_f, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chkb2({tag, " res_valid"}, r_res_valid, f_res_valid, 1'b0);
        chkb2({tag, " res_id"},    r_res_id,    f_res_id,    1'b0);
        chkb2({tag, " res_uflow"}, r_res_uflow, f_res_uflow, 1'b0);
        chkb2({tag, " res_oflow"}, r_res_oflow, f_res_oflow, 1'b0);
        chkw2({tag, " res_prod"},  r_res_prod,  f_res_prod,  32'h0000_0000);
        chkw2({tag, " exc_cnt"},   {24'd0, r_exc_cnt}, {24'd0, f_exc_cnt}, 32'd0);
    endtask

    // One uncontended operation from requester k with res_ready held high.
    // Entered and left at a falling edge with the block in IDLE.
    task automatic op(input logic k, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_prod, input logic exp_uf, input logic exp_of,
                      input logic [7:0] exp_cnt);
        if (k) begin
            in1_valid = 1'b1; in1_a = a; in1_b = b;
        end else begin
            in0_valid = 1'b1; in0_a = a; in0_b = b;
        end
        res_ready = 1'b1;
        #1;
        chkb2("op in0_ready", r_in0_ready, f_in0_ready, !k);
        chkb2("op in1_ready", r_in1_ready, f_in1_ready, k);
        @(negedge clk);                        // handshake edge T passed, CALC
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        chkb2("op calc res_valid", r_res_valid, f_res_valid, 1'b0);
        @(negedge clk);                        // RESP, sampled before edge T+2
        chkb2("op res_valid", r_res_valid, f_res_valid, 1'b1);
        chkw2("op res_prod",  r_res_prod,  f_res_prod,  exp_prod);
        chkb2("op res_id",    r_res_id,    f_res_id,    k);
        chkb2("op res_uflow", r_res_uflow, f_res_uflow, exp_uf);
        chkb2("op res_oflow", r_res_oflow, f_res_oflow, exp_of);
        @(negedge clk);                        // accepted, back in IDLE
        chkb2("op done res_valid", r_res_valid, f_res_valid, 1'b0);
        chkw2("op exc_cnt", {24'd0, r_exc_cnt}, {24'd0, f_exc_cnt}, {24'd0, exp_cnt});
    endtask

    initial begin
        int done;
        int cycles;

        // ---- reset: ready strobes stay low even with both valids high ----
        rst = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1; res_ready = 1'b0;
        in0_a = 32'd0; in0_b = 32'd0; in1_a = 32'd0; in1_b = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chkb2("reset in0_ready", r_in0_ready, f_in0_ready, 1'b0);
        chkb2("reset in1_ready", r_in1_ready, f_in1_ready, 1'b0);
        chk_reset_outputs("reset");
        rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
        @(negedge clk);

        // ---- basic product: 2.0 * 3.0 = 6.0 ----
        op(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 8'd0);

        // ---- contention: fresh reset so requester 0 wins the first round ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in0_valid = 1'b1; in0_a = 32'h4000_0000; in0_b = 32'h4040_0000;
        in1_valid = 1'b1; in1_a = 32'h3F80_0000; in1_b = 32'hBFC0_0000;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = i[0];
            #1;
            // A ready strobe every third falling edge means a handshake every 3 cycles.
            chkb("rr grant in0_ready", r_in0_ready, !g);
            chkb("rr grant in1_ready", r_in1_ready, g);
            chkb("fp grant in0_ready", f_in0_ready, 1'b1);
            chkb("fp grant in1_ready", f_in1_ready, 1'b0);
            @(negedge clk);
            chkb2("cont calc in0_ready", r_in0_ready, f_in0_ready, 1'b0);
            chkb2("cont calc in1_ready", r_in1_ready, f_in1_ready, 1'b0);
            @(negedge clk);
            chkb2("cont resp in0_ready", r_in0_ready, f_in0_ready, 1'b0);
            chkb2("cont resp in1_ready", r_in1_ready, f_in1_ready, 1'b0);
            chkb2("cont res_valid", r_res_valid, f_res_valid, 1'b1);
            chk("rr cont res_prod", r_res_prod, g ? 32'hBFC0_0000 : 32'h40C0_0000);
            chkb("rr cont res_id", r_res_id, g);
            chk("fp cont res_prod", f_res_prod, 32'h40C0_0000);
            chkb("fp cont res_id", f_res_id, 1'b0);
            @(negedge clk);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(negedge clk);

        // ---- overflow then underflow from requester 1 ----
        op(1'b1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0, 1'b1, 8'd1);
        op(1'b1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1, 1'b0, 8'd2);

        // ---- back-pressure: res_ready low for 5 cycles in RESP ----
        in0_valid = 1'b1; in0_a = 32'h4000_0000; in0_b = 32'h4040_0000;
        res_ready = 1'b0;
        #1;
        chkb2("hold in0_ready", r_in0_ready, f_in0_ready, 1'b1);
        @(negedge clk);
        in0_valid = 1'b0;
        @(negedge clk);
        in0_valid = 1'b1; in1_valid = 1'b1;   // requests during RESP must be ignored
        for (int j = 0; j < 5; j++) begin
            #1;
            chkb2("hold res_valid", r_res_valid, f_res_valid, 1'b1);
            chkw2("hold res_prod",  r_res_prod,  f_res_prod,  32'h40C0_0000);
            chkb2("hold res_id",    r_res_id,    f_res_id,    1'b0);
            chkb2("hold in0_ready", r_in0_ready, f_in0_ready, 1'b0);
            chkb2("hold in1_ready", r_in1_ready, f_in1_ready, 1'b0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chkw2("hold last res_prod", r_res_prod, f_res_prod, 32'h40C0_0000);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chkb2("hold released res_valid", r_res_valid, f_res_valid, 1'b0);
        chkb2("hold idle any ready", r_in0_ready | r_in1_ready, f_in0_ready | f_in1_ready, 1'b1);
        chkw2("hold exc_cnt", {24'd0, r_exc_cnt}, {24'd0, f_exc_cnt}, 32'd2);
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(negedge clk);

        // ---- reset during CALC discards the operation ----
        in0_valid = 1'b1; in0_a = 32'h4000_0000; in0_b = 32'h4040_0000;
        res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chkb2("rst calc in0_ready", r_in0_ready, f_in0_ready, 1'b0);
        chkb2("rst calc in1_ready", r_in1_ready, f_in1_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
        chk_reset_outputs("rst calc");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chkb2("rst calc no res_valid", r_res_valid, f_res_valid, 1'b0);
        end
        // 1.0 * 3.0 = 3.0
        op(1'b0, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0, 8'd0);

        // ---- 300 overflow results saturate exc_cnt at 255 ----
        in1_valid = 1'b1; in1_a = 32'h7F00_0000; in1_b = 32'h7F00_0000;
        res_ready = 1'b1;
        done   = 0;
        cycles = 0;
        while (done < 300 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (r_res_valid) begin
                if (done == 254 || done == 255 || done == 299)
                    chkw2("sat exc_cnt", {24'd0, r_exc_cnt}, {24'd0, f_exc_cnt},
                          (done > 255) ? 32'd255 : 32'(done));
                done++;
            end
        end
        chk("sat completions", 32'(done), 32'd300);
        @(negedge clk);
        in1_valid = 1'b0;
        chkw2("sat final exc_cnt", {24'd0, r_exc_cnt}, {24'd0, f_exc_cnt}, 32'd255);
        chkb2("sat final res_oflow", r_res_oflow, f_res_oflow, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
